pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the 5-stage ARM core; replaces the hard-tied freeze/flush constants and the fixed two-stage hazard comparator.
- Keeps an internal scoreboard of in-flight destinations from EXE to WB and generates IF/ID stall, ID/EXE bubble insertion, branch flush, and a global freeze driven by a not-ready memory stage.
- Supports full stall mode (no forwarding) and forwarding mode (load-use stalls only). Counts hazard stall cycles for performance measurement.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_sb_entry_cmp.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout,
// the pipeline-control bundle and its all-zero NOP value.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W_DEF = 4;
    // Scoreboard dest field is sized for the widest supported specifier; narrower
    // specifiers are zero-extended so every entry compares full-width.
    localparam int REG_W_MAX = 8;

    typedef struct packed {
        logic                 vld;
        logic [REG_W_MAX-1:0] dest;
        logic                 is_ld;
    } sb_entry_t;

    typedef struct packed {
        logic stall_if;
        logic bubble_id;
        logic flush_if;
        logic freeze_all;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_sb_entry_cmp.sv
// Compares one scoreboard entry against the source operands of the ID instruction.
module hazard_sb_entry_cmp
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic                 ent_vld,
    input  logic [REG_W_MAX-1:0] ent_dest,
    input  logic [REG_W-1:0]     id_rn,
    input  logic                 id_rn_used,
    input  logic [REG_W-1:0]     id_src2,
    input  logic                 id_two_src,
    output logic                 match
);

    logic [REG_W_MAX-1:0] rn_ext;
    logic [REG_W_MAX-1:0] src2_ext;

    always_comb begin
        rn_ext                = '0;
        rn_ext[REG_W-1:0]     = id_rn;
        src2_ext              = '0;
        src2_ext[REG_W-1:0]   = id_src2;
        match = ent_vld && ((id_rn_used && (ent_dest == rn_ext)) ||
                            (id_two_src && (ent_dest == src2_ext)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: scoreboard of in-flight destinations,
// IF/ID stall, ID/EXE bubble, branch flush, memory freeze and a stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic             id_rn_used,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             exe_br_taken,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             bubble_id,
    output logic             flush_if,
    output logic             freeze_all,
    output logic [CNT_W-1:0] stall_cnt
);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [DEPTH-1:0]      match;
    logic                  hazard;
    logic                  issue;
    logic                  cnt_inc;
    ctrl_t                 ctrl;

    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        hazard_sb_entry_cmp #(.REG_W(REG_W)) u_cmp (
            .ent_vld    (sb_q[k].vld),
            .ent_dest   (sb_q[k].dest),
            .id_rn      (id_rn),
            .id_rn_used (id_rn_used),
            .id_src2    (id_src2),
            .id_two_src (id_two_src),
            .match      (match[k])
        );
    end

    // With forwarding only a load sitting in EXE cannot be bypassed in time.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN == 0) begin
            hazard = id_valid && (|match);
        end else begin
            hazard = id_valid && match[0] && sb_q[0].is_ld;
        end
    end

    always_comb begin
        ctrl    = CTRL_NOP;
        cnt_inc = 1'b0;
        if (rst) begin
            ctrl = CTRL_NOP;
        end else if (mem_busy) begin
            ctrl.freeze_all = 1'b1;
            ctrl.stall_if   = 1'b1;
        end else if (exe_br_taken) begin
            ctrl.flush_if  = 1'b1;
            ctrl.bubble_id = 1'b1;
        end else if (hazard) begin
            ctrl.stall_if  = 1'b1;
            ctrl.bubble_id = 1'b1;
            cnt_inc        = 1'b1;
        end
    end

    assign issue = id_valid && !ctrl.bubble_id;

    always_comb begin
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.freeze_all) begin
            for (int k = 1; k < DEPTH; k++) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = '0;
            if (issue) begin
                sb_d[0].vld              = id_wb_en;
                sb_d[0].dest[REG_W-1:0]  = id_dest;
                sb_d[0].is_ld            = id_mem_r_en;
            end
        end
        if (cnt_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_if   = ctrl.stall_if;
    assign bubble_id  = ctrl.bubble_id;
    assign flush_if   = ctrl.flush_if;
    assign freeze_all = ctrl.freeze_all;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controller configurations share one set of ID/EXE/MEM inputs.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_rn;
    logic       id_rn_used;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic [3:0] id_dest;
    logic       exe_br_taken;
    logic       mem_busy;

    logic        stall_if_a, bubble_id_a, flush_if_a, freeze_all_a;
    logic [15:0] stall_cnt_a;
    logic        stall_if_b, bubble_id_b, flush_if_b, freeze_all_b;
    logic [15:0] stall_cnt_b;
    logic        stall_if_c, bubble_id_c, flush_if_c, freeze_all_c;
    logic [3:0]  stall_cnt_c;

    logic [3:0] ctrl_a, ctrl_b, ctrl_c;
    assign ctrl_a = {stall_if_a, bubble_id_a, flush_if_a, freeze_all_a};
    assign ctrl_b = {stall_if_b, bubble_id_b, flush_if_b, freeze_all_b};
    assign ctrl_c = {stall_if_c, bubble_id_c, flush_if_c, freeze_all_c};

    // ctrl encoding {stall_if, bubble_id, flush_if, freeze_all}
    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1100;
    localparam logic [3:0] C_BR    = 4'b0110;
    localparam logic [3:0] C_FRZ   = 4'b1001;

    int checks;
    int failures;

    pipe_hazard_ctrl #(.REG_W(4), .DEPTH(2), .FWD_EN(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_br_taken(exe_br_taken),
        .mem_busy(mem_busy), .stall_if(stall_if_a), .bubble_id(bubble_id_a),
        .flush_if(flush_if_a), .freeze_all(freeze_all_a), .stall_cnt(stall_cnt_a));

    pipe_hazard_ctrl #(.REG_W(4), .DEPTH(2), .FWD_EN(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_br_taken(exe_br_taken),
        .mem_busy(mem_busy), .stall_if(stall_if_b), .bubble_id(bubble_id_b),
        .flush_if(flush_if_b), .freeze_all(freeze_all_b), .stall_cnt(stall_cnt_b));

    pipe_hazard_ctrl #(.REG_W(4), .DEPTH(2), .FWD_EN(0), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_br_taken(exe_br_taken),
        .mem_busy(mem_busy), .stall_if(stall_if_c), .bubble_id(bubble_id_c),
        .flush_if(flush_if_c), .freeze_all(freeze_all_c), .stall_cnt(stall_cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] rn, input logic ru,
                          input logic [3:0] s2, input logic ts, input logic wb,
                          input logic ld, input logic [3:0] d);
        id_valid    = v;
        id_rn       = rn;
        id_rn_used  = ru;
        id_src2     = s2;
        id_two_src  = ts;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        id_dest     = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // reset with every request input active: outputs must stay low
        rst = 1'b1; mem_busy = 1'b1; exe_br_taken = 1'b1;
        set_id(1, 4'd1, 1, 4'd2, 1, 1, 1, 4'd3);
        tick; tick;
        #1 chk("rst_ctrl_a", 32'(ctrl_a), 32'(C_NONE));
        chk("rst_ctrl_b", 32'(ctrl_b), 32'(C_NONE));
        rst = 1'b0; mem_busy = 1'b0; exe_br_taken = 1'b0;
        set_id(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0);
        #1 chk("rst_cnt_a", 32'(stall_cnt_a), 32'd0);
        tick;

        // ADD R1,R2,R3 then SUB R2,R1,R3: two stall cycles, no forwarding
        set_id(1, 4'd2, 1, 4'd3, 1, 1, 0, 4'd1);
        #1 chk("add_issue", 32'(ctrl_a), 32'(C_NONE));
        tick;
        set_id(1, 4'd1, 1, 4'd3, 1, 1, 0, 4'd2);
        #1 chk("sub_stall1", 32'(ctrl_a), 32'(C_STALL));
        tick;
        #1 chk("sub_stall2", 32'(ctrl_a), 32'(C_STALL));
        chk("sub_cnt1", 32'(stall_cnt_a), 32'd1);
        tick;
        #1 chk("sub_issue", 32'(ctrl_a), 32'(C_NONE));
        chk("sub_cnt2", 32'(stall_cnt_a), 32'd2);
        tick;

        // ADD R5,R5,R6: own destination is not a hazard
        set_id(1, 4'd5, 1, 4'd6, 1, 1, 0, 4'd5);
        #1 chk("self_match", 32'(ctrl_a), 32'(C_NONE));
        tick;

        // MOV R7,R9 then STR R7,[R8] reading R7 as src2
        set_id(1, 4'd0, 0, 4'd9, 1, 1, 0, 4'd7);
        #1 chk("mov_issue", 32'(ctrl_a), 32'(C_NONE));
        tick;
        set_id(1, 4'd8, 1, 4'd7, 1, 0, 0, 4'd0);
        #1 chk("str_stall1", 32'(ctrl_a), 32'(C_STALL));
        tick;
        #1 chk("str_stall2", 32'(ctrl_a), 32'(C_STALL));
        chk("str_cnt3", 32'(stall_cnt_a), 32'd3);
        tick;
        #1 chk("str_issue", 32'(ctrl_a), 32'(C_NONE));
        chk("str_cnt4", 32'(stall_cnt_a), 32'd4);
        tick;

        // same pair without src2 use: no stall
        set_id(1, 4'd0, 0, 4'd9, 1, 1, 0, 4'd7);
        tick;
        set_id(1, 4'd8, 1, 4'd7, 0, 0, 0, 4'd0);
        #1 chk("str_no_src2", 32'(ctrl_a), 32'(C_NONE));
        tick;

        // taken branch with dependent SUB in ID: squash, no count
        set_id(1, 4'd2, 1, 4'd3, 1, 1, 0, 4'd1);
        tick;
        set_id(1, 4'd1, 1, 4'd3, 1, 1, 0, 4'd2);
        exe_br_taken = 1'b1;
        #1 chk("br_ctrl", 32'(ctrl_a), 32'(C_BR));
        chk("br_cnt", 32'(stall_cnt_a), 32'd4);
        tick;
        exe_br_taken = 1'b0;
        // reader of R2: only hazardous if the squashed SUB had entered the scoreboard
        set_id(1, 4'd2, 1, 4'd10, 1, 1, 0, 4'd9);
        #1 chk("br_squashed", 32'(ctrl_a), 32'(C_NONE));
        chk("br_cnt_hold", 32'(stall_cnt_a), 32'd4);
        tick;

        // ADD R11 then consumer frozen by mem_busy for three cycles
        set_id(1, 4'd12, 1, 4'd13, 1, 1, 0, 4'd11);
        tick;
        set_id(1, 4'd11, 1, 4'd0, 0, 1, 0, 4'd14);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("frz_ctrl", 32'(ctrl_a), 32'(C_FRZ));
            chk("frz_cnt", 32'(stall_cnt_a), 32'd4);
            tick;
        end
        mem_busy = 1'b0;
        #1 chk("frz_resume1", 32'(ctrl_a), 32'(C_STALL));
        tick;
        #1 chk("frz_resume2", 32'(ctrl_a), 32'(C_STALL));
        chk("frz_cnt5", 32'(stall_cnt_a), 32'd5);
        tick;
        #1 chk("frz_issue", 32'(ctrl_a), 32'(C_NONE));
        chk("frz_cnt6", 32'(stall_cnt_a), 32'd6);
        tick;

        // branch while frozen is held until mem_busy drops
        set_id(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0);
        mem_busy = 1'b1; exe_br_taken = 1'b1;
        #1 chk("br_frz", 32'(ctrl_a), 32'(C_FRZ));
        tick;
        mem_busy = 1'b0;
        #1 chk("br_after_frz", 32'(ctrl_a), 32'(C_BR));
        tick;
        exe_br_taken = 1'b0;

        // forwarding mode: load-use stalls once, ALU producer never
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_id(1, 4'd8, 1, 4'd0, 0, 1, 1, 4'd4);
        #1 chk("fwd_ldr", 32'(ctrl_b), 32'(C_NONE));
        tick;
        set_id(1, 4'd4, 1, 4'd6, 1, 1, 0, 4'd5);
        #1 chk("fwd_ld_use", 32'(ctrl_b), 32'(C_STALL));
        tick;
        #1 chk("fwd_ld_release", 32'(ctrl_b), 32'(C_NONE));
        chk("fwd_cnt1", 32'(stall_cnt_b), 32'd1);
        tick;
        set_id(1, 4'd5, 1, 4'd1, 1, 1, 0, 4'd7);
        #1 chk("fwd_alu_use", 32'(ctrl_b), 32'(C_NONE));
        chk("fwd_cnt_hold", 32'(stall_cnt_b), 32'd1);
        tick;

        // ADD R1,R1,R3 held in ID: issue, stall, stall repeating
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_id(1, 4'd1, 1, 4'd3, 1, 1, 0, 4'd1);
        for (int i = 0; i < 21; i++) tick;
        #1 chk("sat_pre_ctrl", 32'(ctrl_c), 32'(C_NONE));
        chk("sat_pre_cnt", 32'(stall_cnt_c), 32'd14);
        tick;
        #1 chk("sat_stall_a", 32'(ctrl_c), 32'(C_STALL));
        tick;
        #1 chk("sat_cnt15", 32'(stall_cnt_c), 32'd15);
        chk("sat_stall_b", 32'(ctrl_c), 32'(C_STALL));
        tick;
        #1 chk("sat_hold", 32'(stall_cnt_c), 32'd15);
        chk("wide_cnt16", 32'(stall_cnt_a), 32'd16);
        tick;
        #1 chk("sat_hold2_stall", 32'(ctrl_c), 32'(C_STALL));
        chk("mid_stall_a", 32'(ctrl_a), 32'(C_STALL));

        // reset in the middle of a stall
        rst = 1'b1;
        #1 chk("rst_mid_ctrl_a", 32'(ctrl_a), 32'(C_NONE));
        chk("rst_mid_ctrl_c", 32'(ctrl_c), 32'(C_NONE));
        tick;
        rst = 1'b0;
        #1 chk("post_rst_ctrl", 32'(ctrl_a), 32'(C_NONE));
        chk("post_rst_cnt", 32'(stall_cnt_a), 32'd0);
        chk("post_rst_cnt_c", 32'(stall_cnt_c), 32'd0);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
